// File: rtl/blink_driver_pkg.sv
// Shared indicator definitions: FSM state encodings and timebase defaults
// used by blink_driver and the other display/indicator blocks.
package blink_driver_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    // 100 ms at 125 MHz
    localparam int unsigned DEFAULT_TICK_CNT_MAX = 32'd12_500_000;
    localparam int unsigned PRE_CNT_W            = 32;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: free-running 0..TICK_CNT_MAX-1 counter while enabled, held at
// zero when disabled or cleared; tick marks the last count of each period.
module tick_gen
    import blink_driver_pkg::*;
#(
    parameter int unsigned TICK_CNT_MAX = DEFAULT_TICK_CNT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [PRE_CNT_W-1:0] pre_cnt_q;
    logic [PRE_CNT_W-1:0] pre_cnt_d;

    assign tick = (pre_cnt_q == PRE_CNT_W'(TICK_CNT_MAX - 1));

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr || !en) begin
            pre_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/blink_driver.sv
// Turns a one-cycle start event into N on/off blinks (or continuous blinking)
// on a registered LED/buzzer output; stop aborts at any time without done.
module blink_driver
    import blink_driver_pkg::*;
#(
    parameter int unsigned TICK_CNT_MAX = DEFAULT_TICK_CNT_MAX,
    parameter int unsigned ON_TICKS     = 2,
    parameter int unsigned OFF_TICKS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] blink_num,
    input  logic       stop,
    output logic       led,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PH_W  = $clog2(max_u(ON_TICKS, OFF_TICKS)) + 1;
    localparam int unsigned REM_W = 4;

    logic [1:0]       state_q, state_d;
    logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
    logic [REM_W-1:0] remaining_q, remaining_d;
    logic             cont_q, cont_d;
    logic             led_q, busy_q, done_q, done_d;
    logic             tick;
    logic             pre_clr_c;
    logic             pre_en_c;

    assign pre_en_c = (state_q != ST_IDLE);

    tick_gen #(
        .TICK_CNT_MAX(TICK_CNT_MAX)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (pre_en_c),
        .clr (pre_clr_c),
        .tick(tick)
    );

    // Next-state, phase counter and blink bookkeeping
    always_comb begin
        state_d     = state_q;
        ph_cnt_d    = ph_cnt_q;
        remaining_d = remaining_q;
        cont_d      = cont_q;
        done_d      = 1'b0;
        pre_clr_c   = 1'b0;

        if (stop) begin
            state_d     = ST_IDLE;
            ph_cnt_d    = '0;
            remaining_d = '0;
            pre_clr_c   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_ON;
                        remaining_d = blink_num;
                        cont_d      = (blink_num == 4'd0);
                        ph_cnt_d    = '0;
                        pre_clr_c   = 1'b1;
                    end
                end
                ST_ON: begin
                    if (tick) begin
                        if (ph_cnt_q == PH_W'(ON_TICKS - 1)) begin
                            state_d  = ST_OFF;
                            ph_cnt_d = '0;
                        end else begin
                            ph_cnt_d = ph_cnt_q + PH_W'(1);
                        end
                    end
                end
                ST_OFF: begin
                    if (tick) begin
                        if (ph_cnt_q == PH_W'(OFF_TICKS - 1)) begin
                            ph_cnt_d = '0;
                            if (cont_q) begin
                                state_d = ST_ON;
                            end else if (remaining_q == REM_W'(1)) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d     = ST_ON;
                                remaining_d = remaining_q - REM_W'(1);
                            end
                        end else begin
                            ph_cnt_d = ph_cnt_q + PH_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    ph_cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ph_cnt_q    <= '0;
            remaining_q <= '0;
            cont_q      <= 1'b0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_cnt_q    <= ph_cnt_d;
            remaining_q <= remaining_d;
            cont_q      <= cont_d;
            led_q       <= (state_d == ST_ON);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/blink_driver.md
# blink_driver

Output-side counterpart to the key debouncer. Key conditioning turns a slow physical input into a one-cycle event; this block turns a one-cycle event into a slow, human-visible LED/buzzer pattern. It drives N on/off blinks, or blinks continuously, for the detonator's status and alarm indication. It sits between the controller FSM and the board LED/buzzer pins.

## Interface
- `TICK_CNT_MAX`, default 12_500_000: clocks per tick (100 ms at 125 MHz); must be ≥ 2.
- `ON_TICKS`, default 2: ticks per ON phase; must be ≥ 1.
- `OFF_TICKS`, default 3: ticks per OFF phase; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset; sampled on `clk` rising edge.
- `start` in 1: one-cycle request pulse; ignored while `busy`.
- `blink_num` in 4: blink count, sampled only with an accepted `start`; 0 means continuous.
- `stop` in 1: abort request, level or pulse; acts on any edge where it is high.
- `led` out 1: pattern output, registered.
- `busy` out 1: high from the accepted `start` until return to IDLE.
- `done` out 1: one-cycle pulse on normal completion only.

## Operation
- FSM states: IDLE, ON, OFF.
- IDLE → ON: `start`=1, `stop`=0. On this transition:
  - latch `remaining` = `blink_num`, and set `cont` = (`blink_num`==0);
  - clear the prescaler and the phase counter.
- Prescaler `pre_cnt` (32 b): counts 0..TICK_CNT_MAX-1 while not IDLE, then wraps to 0. `tick` = (`pre_cnt`==TICK_CNT_MAX-1).
- Phase counter `ph_cnt`: increments on `tick` and clears on every phase change.
  - ON ends on `tick` with `ph_cnt`==ON_TICKS-1.
  - OFF ends on `tick` with `ph_cnt`==OFF_TICKS-1.
- ON → OFF: at the end of the ON phase.
- OFF → next state, at the end of the OFF phase:
  - if `cont`, go to ON;
  - else if `remaining`==1, go to IDLE and pulse `done`;
  - else go to ON and decrement `remaining`.
- `stop`=1 in any state: next state is IDLE, `led`=0, counters cleared, no `done`.
- `stop` and `start` on the same edge in IDLE: `stop` wins and the block stays IDLE.
- `start` while busy: ignored, and `blink_num` is not resampled.
- `led`=1 exactly while the state is ON. `busy`=1 while the state is not IDLE.

## Timing
- Reset values: state IDLE, `led`=0, `busy`=0, `done`=0, all counters 0.
- Reset mid-pattern: outputs reach their reset values on the next edge.
- Start latency: with `start` high at edge k, `led` and `busy` are 1 from edge k+1.
- Phase lengths, exact:
  - ON: ON_TICKS·TICK_CNT_MAX cycles.
  - OFF: OFF_TICKS·TICK_CNT_MAX cycles.
- Finite pattern: `busy` stays high for `blink_num`·(ON_TICKS+OFF_TICKS)·TICK_CNT_MAX cycles.
- `done` is high for the single cycle in which `busy` first reads 0.
- Back-to-back: a `start` on the edge where `busy` is 0 is accepted. The earliest such edge is the one that closes the `done` cycle.
- Width rules:
  - `remaining` is 4 b; `blink_num`=15 gives 15 blinks.
  - `ph_cnt` width is $clog2(max(ON_TICKS,OFF_TICKS))+1.

## Structure
- Shared package: state encodings (IDLE=2'd0, ON=2'd1, OFF=2'd2) and the default tick constant, for reuse by the other display/indicator blocks.
- Sub-module `tick_gen`: the prescaler.
  - Inputs: `clk`, `rst`, `en`, `clr`.
  - Output: `tick`.
  - Same counter style as the debouncer timebase.
- FSM, phase counter and `remaining` live in `blink_driver`.

## Test plan
All scenarios use TICK_CNT_MAX=4, ON_TICKS=2, OFF_TICKS=3.
- Reset: hold `rst`=0 for 3 cycles with `start`=1 → `led`, `busy`, `done` all 0 throughout.
- Basic count: `start` with `blink_num`=3 → 3 `led` pulses, each 8 cycles high / 12 low, first high one cycle after `start`. `busy` high for 60 cycles, then one `done` pulse.
- Continuous plus stop:
  - `blink_num`=0 → blinking continues past 200 cycles with no `done`;
  - `stop` mid-ON → `led`=0 and `busy`=0 next edge, no `done`.
- Ignored start: `blink_num`=2 run; `start` with `blink_num`=5 at cycle 10 → still exactly 2 blinks.
- Simultaneous events:
  - `start` and `stop` on the same edge in IDLE → remains IDLE;
  - `start` on the first edge where `busy` is 0 after `done` → new pattern starts one cycle later.
- Reset mid-OFF phase (`rst`=0 for 1 cycle) → all outputs 0 next edge. A following `start` produces full-length phases (prescaler cleared).
